// File: rtl/dmem_sized.sv
// dmem_sized: handshaked data memory with byte/half/word access.
//
// One request is in flight at a time. A request is accepted in IDLE, waits
// LATENCY cycles, commits on the edge that enters RESP, and answers with a
// one-cycle resp_valid strobe.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | req_ready=1, waiting for a request
// WAIT  | request latched, access-latency down-counter running
// RESP  | resp_valid=1 for one cycle; readdata/err hold the result
//
// Ports:
//   clk           clock, all logic on rising edge
//   reset         synchronous active-high reset
//   req_valid     request present
//   req_ready     block can accept a request this cycle
//   req_we        1 = store, 0 = load
//   req_size      0 = byte, 1 = half, 2 = word, 3 = reserved
//   req_unsigned  load zero-extends when 1, sign-extends when 0
//   addr          byte address (little-endian lanes)
//   writedata     store data, right-aligned
//   resp_valid    one-cycle response strobe
//   readdata      extended load data; 0 for stores and errors
//   err           misaligned, reserved size or out-of-range access
module dmem_sized #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic        resp_valid,
  output logic [31:0] readdata,
  output logic        err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam bit          ZERO_LAT  = (LATENCY == 0);
  localparam logic [2:0]  CNT_LOAD  = 3'((LATENCY > 0) ? (LATENCY - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] readdata_q, readdata_d;
  logic        err_q, err_d;

  logic        commit_fsm;
  logic        commit;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero latency the commit happens on the accept edge, before the
  // request registers are loaded, so the access is decoded from the ports.
  logic        c_we;
  logic [1:0]  c_size;
  logic        c_uns;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;

  assign c_we    = ZERO_LAT ? req_we       : we_q;
  assign c_size  = ZERO_LAT ? req_size     : size_q;
  assign c_uns   = ZERO_LAT ? req_unsigned : uns_q;
  assign c_addr  = ZERO_LAT ? addr         : addr_q;
  assign c_wdata = ZERO_LAT ? writedata    : wdata_q;

  // Access decode
  logic [AW-1:0] word_idx;
  logic          out_of_range;
  logic          misaligned;
  logic          acc_err;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;
  logic [3:0]    byte_en;
  logic [31:0]   wr_lanes;
  logic          mem_we;

  assign word_idx     = c_addr[AW+1:2];
  // No wrap-around: any set bit above the index field is out of range.
  assign out_of_range = |c_addr[31:AW+2];
  assign rd_word      = mem[word_idx];
  assign rd_byte      = rd_word[{c_addr[1:0], 3'b000} +: 8];
  assign rd_half      = rd_word[{c_addr[1], 4'b0000} +: 16];

  always_comb begin
    misaligned = 1'b0;
    load_data  = 32'd0;
    byte_en    = 4'b0000;
    wr_lanes   = c_wdata;
    case (c_size)
      2'd0: begin
        load_data = c_uns ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        byte_en   = 4'b0001 << c_addr[1:0];
        wr_lanes  = {4{c_wdata[7:0]}};
      end
      2'd1: begin
        misaligned = c_addr[0];
        load_data  = c_uns ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
        byte_en    = c_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes   = {2{c_wdata[15:0]}};
      end
      2'd2: begin
        misaligned = (c_addr[1:0] != 2'b00);
        load_data  = rd_word;
        byte_en    = 4'b1111;
        wr_lanes   = c_wdata;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

  assign acc_err = misaligned || out_of_range;
  assign commit  = commit_fsm && !reset;
  assign mem_we  = commit && c_we && !acc_err;

  // FSM next-state and outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    commit_fsm = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = addr;
          wdata_d = writedata;
          if (ZERO_LAT) begin
            state_d    = ST_RESP;
            commit_fsm = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d    = ST_RESP;
          commit_fsm = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    readdata_d = readdata_q;
    err_d      = err_q;
    if (commit) begin
      err_d      = acc_err;
      readdata_d = (acc_err || c_we) ? 32'd0 : load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      readdata_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      readdata_q <= readdata_d;
      err_q      <= err_d;
    end
  end

  // Contents survive reset; mem_we is already blocked while reset is high.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && byte_en[i]) begin
        mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  assign readdata = readdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dmem_sized.sv
module tb_dmem_sized;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3;
  logic        v1, v3;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr, wdata;

  logic        rdy1, rv1, err1;
  logic [31:0] rd1;
  logic        rdy3, rv3, err3;
  logic [31:0] rd3;

  dmem_sized #(.DEPTH_WORDS(64), .LATENCY(1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset(rst1), .req_valid(v1), .req_ready(rdy1),
    .req_we(we), .req_size(size), .req_unsigned(uns), .addr(addr),
    .writedata(wdata), .resp_valid(rv1), .readdata(rd1), .err(err1)
  );

  dmem_sized #(.DEPTH_WORDS(64), .LATENCY(3), .INIT_FILE("")) dut3 (
    .clk(clk), .reset(rst3), .req_valid(v3), .req_ready(rdy3),
    .req_we(we), .req_size(size), .req_unsigned(uns), .addr(addr),
    .writedata(wdata), .resp_valid(rv3), .readdata(rd3), .err(err3)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  bit started = 1'b0;

  // Expected timeline per DUT (index 0: LATENCY=1, index 1: LATENCY=3)
  int          exp_resp [2] = '{-1, -1};
  int          busy_lo  [2] = '{-1, -1};
  int          busy_hi  [2] = '{-1, -1};
  logic [31:0] exp_rd   [2];
  logic        exp_err  [2];

  // Byte-addressed reference memory; key = dut index << 20 | byte address
  logic [7:0] mmem [int];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void model(input int k, input bit w, input logic [1:0] sz, input bit u,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] r, output logic e);
    int          base;
    int          nb;
    logic [31:0] v;
    base = k << 20;
    e = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) ||
        ((a >> 2) >= 32'd64);
    r = 32'd0;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    v = 32'd0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < nb; i++) mmem[base + int'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mmem[base + int'(a) + i];
        case (sz)
          2'd0:    r = u ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
          2'd1:    r = u ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
          default: r = v;
        endcase
      end
    end
  endfunction

  // Per-cycle compare of both DUTs against the model timeline
  always @(negedge clk) begin
    logic        a_rdy, a_rv, a_err, e_rdy, e_rv;
    logic [31:0] a_rd;
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        a_rdy = (k == 0) ? rdy1 : rdy3;
        a_rv  = (k == 0) ? rv1  : rv3;
        a_err = (k == 0) ? err1 : err3;
        a_rd  = (k == 0) ? rd1  : rd3;
        e_rdy = !(cyc >= busy_lo[k] && cyc <= busy_hi[k]);
        e_rv  = (cyc == exp_resp[k]);
        check($sformatf("req_ready[dut%0d]", k), {31'd0, a_rdy}, {31'd0, e_rdy});
        check($sformatf("resp_valid[dut%0d]", k), {31'd0, a_rv}, {31'd0, e_rv});
        if (e_rv) begin
          check($sformatf("readdata[dut%0d]", k), a_rd, exp_rd[k]);
          check($sformatf("err[dut%0d]", k), {31'd0, a_err}, {31'd0, exp_err[k]});
        end
      end
    end
  end

  task automatic do_req(input int k, input bit w, input logic [1:0] sz, input bit u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit chk, input logic [31:0] lit_rd, input bit lit_err,
                        input bit toggle);
    int          c;
    logic [31:0] r;
    logic        e;
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = wd;
    if (k == 0) v1 = 1'b1; else v3 = 1'b1;
    c = cyc;
    model(k, w, sz, u, a, wd, r, e);
    exp_rd[k]   = r;
    exp_err[k]  = e;
    busy_lo[k]  = c + 1;
    busy_hi[k]  = c + 1 + lat(k);
    exp_resp[k] = c + 1 + lat(k);
    @(negedge clk);
    v1 = 1'b0; v3 = 1'b0;
    while (cyc < exp_resp[k]) begin
      if (toggle) begin
        v3    = cyc[0];
        addr  = $urandom;
        we    = 1'($urandom);
        wdata = $urandom;
      end
      @(negedge clk);
    end
    v1 = 1'b0; v3 = 1'b0;
    if (chk) begin
      check("lit_resp_valid", {31'd0, (k == 0) ? rv1 : rv3}, 32'd1);
      check("lit_readdata", (k == 0) ? rd1 : rd3, lit_rd);
      check("lit_err", {31'd0, (k == 0) ? err1 : err3}, {31'd0, lit_err});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    rst1 = 1'b1; rst3 = 1'b1; v1 = 1'b0; v3 = 1'b0;
    we = 1'b0; size = 2'd0; uns = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("reset_ready1", {31'd0, rdy1}, 32'd1);
    check("reset_rv1", {31'd0, rv1}, 32'd0);
    check("reset_rd1", rd1, 32'd0);
    check("reset_err1", {31'd0, err1}, 32'd0);
    check("reset_ready3", {31'd0, rdy3}, 32'd1);
    check("reset_rv3", {31'd0, rv3}, 32'd0);
    started = 1'b1;

    // LATENCY=1: word round trip
    do_req(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 0, 0);
    do_req(0, 0, 2'd2, 0, 32'h10, 32'h0,       1, 32'hDEADBEEF, 0, 0);

    // Sub-word stores and extended loads
    do_req(0, 1, 2'd2, 0, 32'h20, 32'h0,        0, 32'h0, 0, 0);
    do_req(0, 1, 2'd0, 0, 32'h21, 32'hFFFFFF80, 0, 32'h0, 0, 0);
    do_req(0, 1, 2'd1, 0, 32'h22, 32'hABCD1234, 0, 32'h0, 0, 0);
    do_req(0, 0, 2'd2, 0, 32'h20, 32'h0, 1, 32'h12348000, 0, 0);
    do_req(0, 0, 2'd0, 0, 32'h21, 32'h0, 1, 32'hFFFFFF80, 0, 0);
    do_req(0, 0, 2'd0, 1, 32'h21, 32'h0, 1, 32'h00000080, 0, 0);
    do_req(0, 0, 2'd1, 0, 32'h22, 32'h0, 1, 32'h00001234, 0, 0);
    do_req(0, 0, 2'd1, 0, 32'h20, 32'h0, 1, 32'hFFFF8000, 0, 0);
    do_req(0, 0, 2'd1, 1, 32'h20, 32'h0, 1, 32'h00008000, 0, 0);
    do_req(0, 0, 2'd0, 1, 32'h23, 32'h0, 1, 32'h00000012, 0, 0);

    // Error cases leave memory untouched
    do_req(0, 1, 2'd2, 0, 32'h04, 32'h01020304, 0, 32'h0, 0, 0);
    do_req(0, 1, 2'd2, 0, 32'h30, 32'h0A0B0C0D, 0, 32'h0, 0, 0);
    do_req(0, 1, 2'd1, 0, 32'h23, 32'h0000FFFF, 1, 32'h0, 1, 0);
    do_req(0, 0, 2'd2, 0, 32'h06, 32'h0,        1, 32'h0, 1, 0);
    do_req(0, 1, 2'd3, 0, 32'h30, 32'hFFFFFFFF, 1, 32'h0, 1, 0);
    do_req(0, 1, 2'd2, 0, 32'h100, 32'hFFFFFFFF, 1, 32'h0, 1, 0);
    do_req(0, 0, 2'd2, 0, 32'h100, 32'h0,       1, 32'h0, 1, 0);
    do_req(0, 0, 2'd2, 0, 32'h20, 32'h0, 1, 32'h12348000, 0, 0);
    do_req(0, 0, 2'd2, 0, 32'h04, 32'h0, 1, 32'h01020304, 0, 0);
    do_req(0, 0, 2'd2, 0, 32'h30, 32'h0, 1, 32'h0A0B0C0D, 0, 0);

    // LATENCY=3 with req_valid toggling while busy
    do_req(1, 1, 2'd2, 0, 32'h40, 32'h5A5A0001, 1, 32'h0, 0, 1);
    do_req(1, 0, 2'd2, 0, 32'h40, 32'h0, 1, 32'h5A5A0001, 0, 1);
    do_req(1, 0, 2'd0, 0, 32'h43, 32'h0, 1, 32'h0000005A, 0, 1);

    // LATENCY=3: reset in the second WAIT cycle drops the store
    do_req(1, 1, 2'd2, 0, 32'h08, 32'h11111111, 0, 32'h0, 0, 0);
    @(negedge clk);
    we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h08; wdata = 32'hAAAA5555; v3 = 1'b1;
    c = cyc;
    busy_lo[1] = c + 1; busy_hi[1] = c + 4; exp_resp[1] = -1;
    @(negedge clk);
    v3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    busy_hi[1] = c + 2;
    @(negedge clk);
    rst3 = 1'b0;
    check("post_reset_ready3", {31'd0, rdy3}, 32'd1);
    check("post_reset_rv3", {31'd0, rv3}, 32'd0);
    do_req(1, 0, 2'd2, 0, 32'h08, 32'h0, 1, 32'h11111111, 0, 0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
